// File: rtl/weapon_sequencer.sv
// -----------------------------------------------------------------------------
// weapon_sequencer
//
// Sequences the player weapon's sprite animation and ammunition. Fire and
// reload button rises are turned into a one-hot weapon state, a sprite frame
// selector paced by the once-per-video-frame tick, and a single-cycle
// shot pulse for the enemy logic. This block owns the only ammo count.
//
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  synchronous, active-low reset
//   frame_tick   in   1  one-clk pulse per video frame
//   fire         in   1  synchronized fire button level
//   reload_req   in   1  synchronized reload button level
//   game_active  in   1  high during play, low on the title screen
//   weapon_state out  3  3'b001 IDLE, 3'b010 FIRE, 3'b100 RELOAD
//   frame_idx    out  2  sprite frame within the current animation
//   ammo         out  2  shells remaining, 0..SHELLS
//   shot_fired   out  1  one-cycle pulse when a shell is spent
//   busy         out  1  high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module weapon_sequencer #(
  parameter int FRAME_TICKS   = 6,
  parameter int SHOOT_FRAMES  = 2,
  parameter int RELOAD_FRAMES = 4,
  parameter int SHELLS        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic       reload_req,
  input  logic       game_active,
  output logic [2:0] weapon_state,
  output logic [1:0] frame_idx,
  output logic [1:0] ammo,
  output logic       shot_fired,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_FIRE   = 3'b010,
    ST_RELOAD = 3'b100
  } state_t;

  localparam logic [3:0] TICK_LAST   = 4'(FRAME_TICKS - 1);
  localparam logic [1:0] SHOOT_LAST  = 2'(SHOOT_FRAMES - 1);
  localparam logic [1:0] RELOAD_LAST = 2'(RELOAD_FRAMES - 1);
  localparam logic [1:0] AMMO_FULL   = 2'(SHELLS);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] tick_cnt_r;
  logic [3:0] tick_cnt_s;
  logic [1:0] frame_idx_r;
  logic [1:0] frame_idx_s;
  logic [1:0] ammo_r;
  logic [1:0] ammo_s;
  logic       shot_r;
  logic       shot_s;
  logic       busy_r;
  logic       busy_s;
  logic       fire_q;
  logic       reload_q;
  logic       fire_rise_r;
  logic       reload_rise_r;

  // Edge detection. The rise itself is registered, so the FSM acts on a rise
  // one edge after it is sampled; rises seen while the game is inactive are
  // never recorded, so they cannot leak into play when it resumes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fire_q        <= 1'b0;
      reload_q      <= 1'b0;
      fire_rise_r   <= 1'b0;
      reload_rise_r <= 1'b0;
    end else begin
      fire_q        <= fire;
      reload_q      <= reload_req;
      fire_rise_r   <= fire & ~fire_q & game_active;
      reload_rise_r <= reload_req & ~reload_q & game_active;
    end
  end

  // State and animation registers; all outputs come straight from here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      tick_cnt_r  <= 4'd0;
      frame_idx_r <= 2'd0;
      ammo_r      <= AMMO_FULL;
      shot_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      tick_cnt_r  <= tick_cnt_s;
      frame_idx_r <= frame_idx_s;
      ammo_r      <= ammo_s;
      shot_r      <= shot_s;
      busy_r      <= busy_s;
    end
  end

  // Next-state, animation pacing and ammo bookkeeping.
  always_comb begin
    state_s     = state_r;
    tick_cnt_s  = tick_cnt_r;
    frame_idx_s = frame_idx_r;
    ammo_s      = ammo_r;
    shot_s      = 1'b0;

    if (!game_active) begin
      // Title screen: force a fresh, fully loaded weapon.
      state_s     = ST_IDLE;
      tick_cnt_s  = 4'd0;
      frame_idx_s = 2'd0;
      ammo_s      = AMMO_FULL;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tick_cnt_s  = 4'd0;
          frame_idx_s = 2'd0;
          // Fire is checked first so it wins over a simultaneous reload.
          if (fire_rise_r) begin
            if (ammo_r != 2'd0) begin
              state_s = ST_FIRE;
              ammo_s  = ammo_r - 2'd1;
              shot_s  = 1'b1;
            end else begin
              state_s = ST_RELOAD;
            end
          end else if (reload_rise_r && (ammo_r < AMMO_FULL)) begin
            state_s = ST_RELOAD;
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_FIRE: begin
          if (frame_tick) begin
            if (tick_cnt_r == TICK_LAST) begin
              tick_cnt_s = 4'd0;
              if (frame_idx_r == SHOOT_LAST) begin
                frame_idx_s = 2'd0;
                // An emptied magazine rolls straight into the reload.
                if (ammo_r == 2'd0) begin
                  state_s = ST_RELOAD;
                end else begin
                  state_s = ST_IDLE;
                end
              end else begin
                frame_idx_s = frame_idx_r + 2'd1;
              end
            end else begin
              tick_cnt_s = tick_cnt_r + 4'd1;
            end
          end else begin
            tick_cnt_s = tick_cnt_r;
          end
        end

        ST_RELOAD: begin
          if (frame_tick) begin
            if (tick_cnt_r == TICK_LAST) begin
              tick_cnt_s = 4'd0;
              if (frame_idx_r == RELOAD_LAST) begin
                frame_idx_s = 2'd0;
                ammo_s      = AMMO_FULL;
                state_s     = ST_IDLE;
              end else begin
                frame_idx_s = frame_idx_r + 2'd1;
              end
            end else begin
              tick_cnt_s = tick_cnt_r + 4'd1;
            end
          end else begin
            tick_cnt_s = tick_cnt_r;
          end
        end

        default: begin
          // Unreachable encodings recover to a clean idle.
          state_s     = ST_IDLE;
          tick_cnt_s  = 4'd0;
          frame_idx_s = 2'd0;
        end
      endcase
    end

    busy_s = (state_s != ST_IDLE);
  end

  assign weapon_state = state_r;
  assign frame_idx    = frame_idx_r;
  assign ammo         = ammo_r;
  assign shot_fired   = shot_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_weapon_sequencer.sv
// -----------------------------------------------------------------------------
// tb_weapon_sequencer
//
// Directed bench for weapon_sequencer with default parameters. Inputs change
// 1 time unit after each rising edge and outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_weapon_sequencer;

  localparam logic [2:0] S_IDLE   = 3'b001;
  localparam logic [2:0] S_FIRE   = 3'b010;
  localparam logic [2:0] S_RELOAD = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       fire;
  logic       reload_req;
  logic       game_active;
  logic [2:0] weapon_state;
  logic [1:0] frame_idx;
  logic [1:0] ammo;
  logic       shot_fired;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int shot_cnt = 0;

  weapon_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .fire         (fire),
    .reload_req   (reload_req),
    .game_active  (game_active),
    .weapon_state (weapon_state),
    .frame_idx    (frame_idx),
    .ammo         (ammo),
    .shot_fired   (shot_fired),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle; counts shot pulses seen.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (shot_fired === 1'b1) shot_cnt++;
  endtask

  // n isolated frame_tick pulses.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; fire = 1'b0; reload_req = 1'b0; game_active = 1'b1;
    cycle(); cycle();
    check_val("rst_state", 8'(weapon_state), 8'(S_IDLE));
    check_val("rst_frame", 8'(frame_idx), 8'd0);
    check_val("rst_ammo",  8'(ammo), 8'd2);
    check_val("rst_shot",  8'(shot_fired), 8'd0);
    check_val("rst_busy",  8'(busy), 8'd0);
    rst_n = 1'b1;
    cycle();

    // Single fire: latency, pulse width, frame pacing, return to idle.
    fire = 1'b1; cycle();
    check_val("fire_lat_idle", 8'(weapon_state), 8'(S_IDLE));
    fire = 1'b0; cycle();
    check_val("fire1_state", 8'(weapon_state), 8'(S_FIRE));
    check_val("fire1_busy",  8'(busy), 8'd1);
    check_val("fire1_ammo",  8'(ammo), 8'd1);
    check_val("fire1_shot",  8'(shot_fired), 8'd1);
    cycle();
    check_val("fire1_shot_off", 8'(shot_fired), 8'd0);
    tick_n(5);
    check_val("fire1_t5_frame", 8'(frame_idx), 8'd0);
    tick_n(1);
    check_val("fire1_t6_frame", 8'(frame_idx), 8'd1);
    tick_n(5);
    check_val("fire1_t11_state", 8'(weapon_state), 8'(S_FIRE));
    check_val("fire1_t11_frame", 8'(frame_idx), 8'd1);
    tick_n(1);
    check_val("fire1_t12_state", 8'(weapon_state), 8'(S_IDLE));
    check_val("fire1_t12_busy",  8'(busy), 8'd0);

    // Second fire empties the magazine and chains into reload.
    fire = 1'b1; cycle(); fire = 1'b0; cycle();
    check_val("fire2_ammo", 8'(ammo), 8'd0);
    tick_n(12);
    check_val("fire2_to_reload", 8'(weapon_state), 8'(S_RELOAD));
    check_val("reload_f0", 8'(frame_idx), 8'd0);
    tick_n(6);
    check_val("reload_f1", 8'(frame_idx), 8'd1);
    tick_n(6);
    check_val("reload_f2", 8'(frame_idx), 8'd2);
    tick_n(6);
    check_val("reload_f3", 8'(frame_idx), 8'd3);
    tick_n(5);
    check_val("reload_t23_state", 8'(weapon_state), 8'(S_RELOAD));
    tick_n(1);
    check_val("reload_done_state", 8'(weapon_state), 8'(S_IDLE));
    check_val("reload_done_ammo",  8'(ammo), 8'd2);

    // Reload with a full magazine is ignored.
    reload_req = 1'b1; cycle(); reload_req = 1'b0; cycle(); cycle();
    check_val("reload_full_state", 8'(weapon_state), 8'(S_IDLE));
    check_val("reload_full_busy",  8'(busy), 8'd0);

    // Fire held: one shot only; a re-press during FIRE is dropped.
    shot_cnt = 0;
    fire = 1'b1; cycle(); cycle();
    check_val("hold_state", 8'(weapon_state), 8'(S_FIRE));
    tick_n(3);
    fire = 1'b0; cycle(); fire = 1'b1; cycle(); cycle();
    check_val("hold_repress_state", 8'(weapon_state), 8'(S_FIRE));
    tick_n(97);
    fire = 1'b0; cycle();
    check_val("hold_shots", 8'(shot_cnt), 8'd1);
    check_val("hold_ammo",  8'(ammo), 8'd1);
    check_val("hold_state_end", 8'(weapon_state), 8'(S_IDLE));

    // Reload with one shell spent.
    reload_req = 1'b1; cycle(); reload_req = 1'b0; cycle();
    check_val("reload1_state", 8'(weapon_state), 8'(S_RELOAD));
    tick_n(23);
    check_val("reload1_t23", 8'(weapon_state), 8'(S_RELOAD));
    tick_n(1);
    check_val("reload1_done", 8'(weapon_state), 8'(S_IDLE));
    check_val("reload1_ammo", 8'(ammo), 8'd2);

    // game_active drop in RELOAD frame 2.
    fire = 1'b1; cycle(); fire = 1'b0; cycle();
    tick_n(12);
    reload_req = 1'b1; cycle(); reload_req = 1'b0; cycle();
    tick_n(12);
    check_val("ga_pre_frame", 8'(frame_idx), 8'd2);
    check_val("ga_pre_state", 8'(weapon_state), 8'(S_RELOAD));
    game_active = 1'b0; cycle();
    check_val("ga_state", 8'(weapon_state), 8'(S_IDLE));
    check_val("ga_ammo",  8'(ammo), 8'd2);
    check_val("ga_frame", 8'(frame_idx), 8'd0);
    shot_cnt = 0;
    fire = 1'b1; cycle(); fire = 1'b0; cycle(); cycle();
    check_val("ga_fire_ignored", 8'(weapon_state), 8'(S_IDLE));
    check_val("ga_fire_shots",   8'(shot_cnt), 8'd0);
    game_active = 1'b1; cycle(); cycle();
    check_val("ga_resume_state", 8'(weapon_state), 8'(S_IDLE));

    // Fire and reload rise together with a coincident tick.
    fire = 1'b1; reload_req = 1'b1; frame_tick = 1'b1; cycle();
    fire = 1'b0; reload_req = 1'b0; frame_tick = 1'b0; cycle();
    check_val("simul_state", 8'(weapon_state), 8'(S_FIRE));
    check_val("simul_ammo",  8'(ammo), 8'd1);
    tick_n(11);
    check_val("simul_t11", 8'(weapon_state), 8'(S_FIRE));
    tick_n(1);
    check_val("simul_t12", 8'(weapon_state), 8'(S_IDLE));

    // Reset mid-animation, with fire held through reset.
    fire = 1'b1; cycle(); fire = 1'b0; cycle();
    tick_n(7);
    fire = 1'b1; rst_n = 1'b0; cycle();
    check_val("mid_rst_state", 8'(weapon_state), 8'(S_IDLE));
    check_val("mid_rst_ammo",  8'(ammo), 8'd2);
    check_val("mid_rst_frame", 8'(frame_idx), 8'd0);
    check_val("mid_rst_busy",  8'(busy), 8'd0);
    rst_n = 1'b1; cycle(); cycle();
    check_val("held_fire_state", 8'(weapon_state), 8'(S_FIRE));
    check_val("held_fire_ammo",  8'(ammo), 8'd1);
    fire = 1'b0; cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
